// File: rtl/iob_wishbone_byte_adapter_pkg.sv
// Shared types and defaults for the 32/16-bit to 8-bit Wishbone byte adapter.
// The optional downstream timeout is enabled by IOB_WISHBONE_BYTE_ADAPTER_TIMEOUT_EN.
package iob_wishbone_byte_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BYTE = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_ADDR_W      = 5;
    localparam int unsigned DEF_UP_DATA_W   = 32;
    localparam int unsigned DEF_TIMEOUT_CYC = 255;

    function automatic int unsigned lanes_of(input int unsigned up_data_w);
        return up_data_w / 8;
    endfunction

endpackage

// File: rtl/iob_wishbone_lane_pick.sv
// Lowest-set-bit finder over the remaining byte-lane mask.
module iob_wishbone_lane_pick #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 2
) (
    input  logic [LANES-1:0]  mask_i,
    output logic [LANE_W-1:0] lane_o,
    output logic              none_o
);

    // Scanning downward leaves the lowest set bit as the final winner.
    always_comb begin
        lane_o = '0;
        for (int unsigned i = LANES; i > 0; i--) begin
            if (mask_i[i-1]) begin
                lane_o = LANE_W'(i - 1);
            end
        end
        none_o = ~|mask_i;
    end

endmodule

// File: rtl/iob_wishbone_byte_adapter.sv
// Splits each upstream 16/32-bit Wishbone access into 8-bit downstream cycles, low lane first.
// Optional timeout per byte: define IOB_WISHBONE_BYTE_ADAPTER_TIMEOUT_EN.
module iob_wishbone_byte_adapter
    import iob_wishbone_byte_adapter_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned UP_DATA_W   = DEF_UP_DATA_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                   clk_i,
    input  logic                   cke_i,
    input  logic                   rst_i,
    input  logic [ADDR_W-1:0]      up_adr_i,
    input  logic [UP_DATA_W-1:0]   up_dat_i,
    input  logic [UP_DATA_W/8-1:0] up_sel_i,
    input  logic                   up_we_i,
    input  logic                   up_cyc_i,
    input  logic                   up_stb_i,
    output logic [UP_DATA_W-1:0]   up_dat_o,
    output logic                   up_ack_o,
    output logic [ADDR_W-1:0]      dn_adr_o,
    output logic [7:0]             dn_dat_o,
    output logic                   dn_we_o,
    output logic                   dn_cyc_o,
    output logic                   dn_stb_o,
    output logic                   dn_sel_o,
    input  logic [7:0]             dn_dat_i,
    input  logic                   dn_ack_i,
    output logic                   err_o
);

    localparam int unsigned LANES  = lanes_of(UP_DATA_W);
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(LANES - 1);

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      adr_q, adr_d;
    logic [UP_DATA_W-1:0]   dat_q, dat_d;
    logic [LANES-1:0]       mask_q, mask_d;
    logic                   we_q, we_d;
    logic [UP_DATA_W-1:0]   acc_q, acc_d;

    logic [LANE_W-1:0]      lane;
    logic                   none_left;
    logic                   byte_done;
    logic                   in_byte;

`ifdef IOB_WISHBONE_BYTE_ADAPTER_TIMEOUT_EN
    logic [7:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;
`endif

    iob_wishbone_lane_pick #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_pick (
        .mask_i (mask_q),
        .lane_o (lane),
        .none_o (none_left)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            mask_q  <= '0;
            we_q    <= 1'b0;
            acc_q   <= '0;
`ifdef IOB_WISHBONE_BYTE_ADAPTER_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else if (cke_i) begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            mask_q  <= mask_d;
            we_q    <= we_d;
            acc_q   <= acc_d;
`ifdef IOB_WISHBONE_BYTE_ADAPTER_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        mask_d    = mask_q;
        we_d      = we_q;
        acc_d     = acc_q;
        byte_done = 1'b0;
`ifdef IOB_WISHBONE_BYTE_ADAPTER_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (up_cyc_i && up_stb_i) begin
                    adr_d   = up_adr_i;
                    dat_d   = up_dat_i;
                    mask_d  = up_sel_i;
                    we_d    = up_we_i;
                    acc_d   = '0;
                    state_d = (up_sel_i != '0) ? BYTE : DONE;
`ifdef IOB_WISHBONE_BYTE_ADAPTER_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end

            BYTE: begin
                if (none_left) begin
                    state_d = DONE;
                end else begin
                    if (dn_ack_i) begin
                        if (!we_q) begin
                            acc_d[8*lane +: 8] = dn_dat_i;
                        end
                        byte_done = 1'b1;
                    end
`ifdef IOB_WISHBONE_BYTE_ADAPTER_TIMEOUT_EN
                    // An unanswered byte is abandoned and reads back as all ones.
                    else if (cnt_q == 8'(TIMEOUT_CYC)) begin
                        if (!we_q) begin
                            acc_d[8*lane +: 8] = 8'hFF;
                        end
                        err_d     = 1'b1;
                        byte_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                    if (byte_done) begin
                        mask_d = mask_q & ~(LANES'(1) << lane);
`ifdef IOB_WISHBONE_BYTE_ADAPTER_TIMEOUT_EN
                        cnt_d  = '0;
`endif
                        if (mask_d == '0) begin
                            state_d = DONE;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_byte  = (state_q == BYTE);
    assign dn_cyc_o = in_byte;
    assign dn_stb_o = in_byte;
    assign dn_sel_o = in_byte;
    assign dn_we_o  = in_byte & we_q;
    assign dn_adr_o = in_byte ? ((adr_q & ~LANE_MASK) | ADDR_W'(lane)) : '0;
    assign dn_dat_o = in_byte ? dat_q[8*lane +: 8] : '0;
    assign up_ack_o = (state_q == DONE);
    assign up_dat_o = acc_q;

`ifdef IOB_WISHBONE_BYTE_ADAPTER_TIMEOUT_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_wishbone_byte_adapter.sv
// Randomized bench for iob_wishbone_byte_adapter against a transaction-level byte-memory model.
module tb_iob_wishbone_byte_adapter;

    logic        clk = 1'b0;
    logic        cke, rst;
    logic [4:0]  up_adr;
    logic [31:0] up_dat_w;
    logic [3:0]  up_sel;
    logic        up_we, up_cyc, up_stb;
    logic [31:0] up_dat_r;
    logic        up_ack;
    logic [4:0]  dn_adr;
    logic [7:0]  dn_dat_w, dn_dat_r;
    logic        dn_we, dn_cyc, dn_stb, dn_sel, dn_ack;
    logic        err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [7:0]  mem [32];

    always #5 clk = ~clk;

    iob_wishbone_byte_adapter #(
        .ADDR_W      (5),
        .UP_DATA_W   (32),
        .TIMEOUT_CYC (255)
    ) dut (
        .clk_i    (clk),
        .cke_i    (cke),
        .rst_i    (rst),
        .up_adr_i (up_adr),
        .up_dat_i (up_dat_w),
        .up_sel_i (up_sel),
        .up_we_i  (up_we),
        .up_cyc_i (up_cyc),
        .up_stb_i (up_stb),
        .up_dat_o (up_dat_r),
        .up_ack_o (up_ack),
        .dn_adr_o (dn_adr),
        .dn_dat_o (dn_dat_w),
        .dn_we_o  (dn_we),
        .dn_cyc_o (dn_cyc),
        .dn_stb_o (dn_stb),
        .dn_sel_o (dn_sel),
        .dn_dat_i (dn_dat_r),
        .dn_ack_i (dn_ack),
        .err_o    (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One upstream access; rst_at >= 0 aborts with reset when that byte index is on the bus.
    task automatic run_txn(input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, input int unsigned wmin, input int unsigned wmax,
                           input bit freeze, input int rst_at);
        logic [4:0]  ea[$];
        int unsigned w[$];
        logic [31:0] erd;
        int unsigned exp_cyc;
        int          idx;
        int unsigned cyc, wcnt;
        bit          froze, done;
        logic [1:0]  ln;

        erd = '0; exp_cyc = 1; idx = 0; cyc = 0; wcnt = 0; froze = 0; done = 0;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) begin
                logic [4:0] a;
                int unsigned ww;
                a  = {adr[4:2], 2'(k)};
                ww = $urandom_range(wmax, wmin);
                ea.push_back(a);
                w.push_back(ww);
                if (!we) erd[8*k +: 8] = mem[a];
                exp_cyc += ww + 1;
            end
        end

        @(negedge clk);
        up_adr = adr; up_dat_w = dat; up_sel = sel; up_we = we; up_cyc = 1'b1; up_stb = 1'b1;
        @(negedge clk);
        up_cyc = 1'b0; up_stb = 1'b0;
        up_adr = 5'($urandom); up_dat_w = $urandom; up_sel = 4'($urandom); up_we = 1'($urandom);
        cyc = 1;

        while (!done && cyc < 300) begin
            dn_ack = 1'b0;
            if (dn_cyc) begin
                if (rst_at >= 0 && idx == rst_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    chk("rst_dn_cyc", 32'(dn_cyc), 0);
                    chk("rst_up_ack", 32'(up_ack), 0);
                    chk("rst_up_dat", up_dat_r, 0);
                    rst = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        chk("rst_no_ack", 32'(up_ack), 0);
                        chk("rst_no_cyc", 32'(dn_cyc), 0);
                    end
                    return;
                end
                if (freeze && !froze) begin
                    froze = 1;
                    cke = 1'b0;
                    dn_ack = 1'b1;
                    repeat (3) begin
                        @(negedge clk);
                        chk("frz_cyc", 32'(dn_cyc), 1);
                        chk("frz_adr", 32'(dn_adr), 32'(ea[idx]));
                        chk("frz_ack", 32'(up_ack), 0);
                    end
                    cke = 1'b1;
                    dn_ack = 1'b0;
                    exp_cyc += 3;
                    cyc += 3;
                end
                if (idx >= ea.size()) begin
                    chk("dn_extra_byte", 32'(idx), 32'(ea.size()));
                    break;
                end
                ln = ea[idx][1:0];
                chk("dn_adr", 32'(dn_adr), 32'(ea[idx]));
                chk("dn_we", 32'(dn_we), 32'(we));
                chk("dn_stb_sel", {30'd0, dn_stb, dn_sel}, 32'd3);
                chk("up_ack_early", 32'(up_ack), 0);
                if (we) chk("dn_dat", 32'(dn_dat_w), 32'(dat[8*ln +: 8]));
                if (wcnt == w[idx]) begin
                    dn_ack = 1'b1;
                    dn_dat_r = mem[ea[idx]];
                    if (we) mem[ea[idx]] = dat[8*ln +: 8];
                    idx++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                    dn_dat_r = 8'($urandom);
                end
            end else if (up_ack) begin
                done = 1;
                chk("up_dat", up_dat_r, erd);
                chk("byte_count", 32'(idx), 32'(ea.size()));
                chk("latency", cyc, exp_cyc);
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        dn_ack = 1'b0;
        if (!done) chk("watchdog_ack", 0, 1);
        @(negedge clk);
        chk("ack_one_cycle", 32'(up_ack), 0);
        chk("up_dat_hold", up_dat_r, erd);
`ifndef IOB_WISHBONE_BYTE_ADAPTER_TIMEOUT_EN
        chk("err_tied", 32'(err), 0);
`endif
    endtask

    initial begin
        cke = 1'b1; rst = 1'b1;
        up_adr = '0; up_dat_w = '0; up_sel = '0; up_we = 1'b0; up_cyc = 1'b0; up_stb = 1'b0;
        dn_dat_r = '0; dn_ack = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_up_ack", 32'(up_ack), 0);
        chk("rst_up_dat", up_dat_r, 0);
        chk("rst_dn_bus", {dn_cyc, dn_stb, dn_sel, dn_we, dn_adr, dn_dat_w}, 0);
        chk("rst_err", 32'(err), 0);

        run_txn(5'h04, 32'h44332211, 4'b1111, 1'b1, 0, 0, 0, -1);
        mem[9] = 8'hA5;
        run_txn(5'h09, 32'hDEADBEEF, 4'b0010, 1'b0, 0, 0, 0, -1);
        chk("t2_word", up_dat_r, 32'h0000A500);
        run_txn(5'h10, 32'h76543210, 4'b0101, 1'b1, 2, 2, 0, -1);
        run_txn(5'h0C, 32'hFFFFFFFF, 4'b0000, 1'b0, 0, 0, 0, -1);
        chk("t4_word", up_dat_r, 32'h0);
        run_txn(5'h18, 32'h0, 4'b1111, 1'b0, 0, 1, 0, 1);
        run_txn(5'h18, 32'h0, 4'b1111, 1'b0, 0, 1, 0, -1);
        run_txn(5'h04, 32'h0, 4'b1111, 1'b0, 0, 0, 0, -1);
        chk("t1_readback", up_dat_r, 32'h44332211);
        run_txn(5'h14, 32'hCAFEF00D, 4'b1010, 1'b1, 0, 2, 1, -1);

        for (int t = 0; t < 60; t++) begin
            run_txn(5'($urandom), $urandom, 4'($urandom), 1'($urandom),
                    0, $urandom_range(3, 0), ($urandom_range(7, 0) == 0), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
